// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: H/V sync, display window, pixel column/row
// and line/frame strobes, advancing one pixel per Clock with iPixelEn high.
module vga_timing_gen #(
   parameter int unsigned XWidth    = 10,
   parameter int unsigned YWidth    = 10,
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter bit          HSYNC_POL = 1'b0,
   parameter bit          VSYNC_POL = 1'b0
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              iPixelEn,
   output logic [XWidth-1:0] oCol,
   output logic [YWidth-1:0] oRow,
   output logic              oHSync,
   output logic              oVSync,
   output logic              oDisplay,
   output logic              oLineStart,
   output logic              oFrameStart
);

   localparam int unsigned CntWidth = 12;
   localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Last count of each phase; a phase ends on the enabled cycle its counter sits here.
   localparam logic [CntWidth-1:0] H_DISP_END  = CntWidth'(H_VISIBLE - 1);
   localparam logic [CntWidth-1:0] H_FRONT_END = CntWidth'(H_VISIBLE + H_FRONT - 1);
   localparam logic [CntWidth-1:0] H_SYNC_END  = CntWidth'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [CntWidth-1:0] H_LAST      = CntWidth'(H_TOTAL - 1);
   localparam logic [CntWidth-1:0] V_DISP_END  = CntWidth'(V_VISIBLE - 1);
   localparam logic [CntWidth-1:0] V_FRONT_END = CntWidth'(V_VISIBLE + V_FRONT - 1);
   localparam logic [CntWidth-1:0] V_SYNC_END  = CntWidth'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic [CntWidth-1:0] V_LAST      = CntWidth'(V_TOTAL - 1);

   typedef enum logic [1:0] {HS_DISPLAY, HS_FRONT, HS_SYNC, HS_BACK} hState_t;
   typedef enum logic [1:0] {VS_DISPLAY, VS_FRONT, VS_SYNC, VS_BACK} vState_t;

   hState_t             hState, hStateNext;
   vState_t             vState, vStateNext;
   logic [CntWidth-1:0] hcnt, hcntNext;
   logic [CntWidth-1:0] vcnt, vcntNext;
   logic                lineEnd;
   logic                visible;

   logic [XWidth-1:0]   colNext;
   logic [YWidth-1:0]   rowNext;
   logic                hSyncNext, vSyncNext, displayNext, lineStartNext, frameStartNext;

   assign lineEnd = (hcnt == H_LAST);
   assign visible = (hState == HS_DISPLAY) && (vState == VS_DISPLAY);

   // State, counter and output registers
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         hState      <= HS_DISPLAY;
         vState      <= VS_DISPLAY;
         hcnt        <= '0;
         vcnt        <= '0;
         oCol        <= '0;
         oRow        <= '0;
         oHSync      <= ~HSYNC_POL;
         oVSync      <= ~VSYNC_POL;
         oDisplay    <= 1'b0;
         oLineStart  <= 1'b0;
         oFrameStart <= 1'b0;
      end else begin
         hState      <= hStateNext;
         vState      <= vStateNext;
         hcnt        <= hcntNext;
         vcnt        <= vcntNext;
         oCol        <= colNext;
         oRow        <= rowNext;
         oHSync      <= hSyncNext;
         oVSync      <= vSyncNext;
         oDisplay    <= displayNext;
         oLineStart  <= lineStartNext;
         oFrameStart <= frameStartNext;
      end
   end

   // Next-state: horizontal phases every enable, vertical phases only on the line wrap
   always_comb begin
      hStateNext = hState;
      vStateNext = vState;
      hcntNext   = hcnt;
      vcntNext   = vcnt;
      if (iPixelEn) begin
         hcntNext = lineEnd ? '0 : hcnt + CntWidth'(1);
         unique case (hState)
            HS_DISPLAY: if (hcnt == H_DISP_END)  hStateNext = HS_FRONT;
            HS_FRONT:   if (hcnt == H_FRONT_END) hStateNext = HS_SYNC;
            HS_SYNC:    if (hcnt == H_SYNC_END)  hStateNext = HS_BACK;
            HS_BACK:    if (lineEnd)             hStateNext = HS_DISPLAY;
         endcase
         if (lineEnd) begin
            vcntNext = (vcnt == V_LAST) ? '0 : vcnt + CntWidth'(1);
            unique case (vState)
               VS_DISPLAY: if (vcnt == V_DISP_END)  vStateNext = VS_FRONT;
               VS_FRONT:   if (vcnt == V_FRONT_END) vStateNext = VS_SYNC;
               VS_SYNC:    if (vcnt == V_SYNC_END)  vStateNext = VS_BACK;
               VS_BACK:    if (vcnt == V_LAST)      vStateNext = VS_DISPLAY;
            endcase
         end
      end
   end

   // Output decode of the current position; strobes drop on idle edges, the rest hold
   always_comb begin
      colNext        = oCol;
      rowNext        = oRow;
      hSyncNext      = oHSync;
      vSyncNext      = oVSync;
      displayNext    = oDisplay;
      lineStartNext  = 1'b0;
      frameStartNext = 1'b0;
      if (iPixelEn) begin
         displayNext    = visible;
         colNext        = visible ? XWidth'(hcnt) : '0;
         rowNext        = (vState == VS_DISPLAY) ? YWidth'(vcnt) : '0;
         hSyncNext      = (hState == HS_SYNC) ? HSYNC_POL : ~HSYNC_POL;
         vSyncNext      = (vState == VS_SYNC) ? VSYNC_POL : ~VSYNC_POL;
         lineStartNext  = (hcnt == '0);
         frameStartNext = (hcnt == '0) && (vcnt == '0);
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: small mode S (both sync polarities) and the default 640x480 mode.
module tb_vga_timing_gen;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       iPixelEn;

   logic [2:0] sCol;   logic [1:0] sRow;
   logic       sHSync, sVSync, sDisplay, sLineStart, sFrameStart;
   logic [2:0] pCol;   logic [1:0] pRow;
   logic       pHSync, pVSync, pDisplay, pLineStart, pFrameStart;
   logic [9:0] dCol;   logic [9:0] dRow;
   logic       dHSync, dVSync, dDisplay, dLineStart, dFrameStart;

   int checks = 0;
   int errors = 0;

   always #5 Clock = ~Clock;

   vga_timing_gen #(.XWidth(3), .YWidth(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) dutS (
      .Clock(Clock), .Reset(Reset), .iPixelEn(iPixelEn), .oCol(sCol), .oRow(sRow),
      .oHSync(sHSync), .oVSync(sVSync), .oDisplay(sDisplay),
      .oLineStart(sLineStart), .oFrameStart(sFrameStart));

   vga_timing_gen #(.XWidth(3), .YWidth(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) dutP (
      .Clock(Clock), .Reset(Reset), .iPixelEn(iPixelEn), .oCol(pCol), .oRow(pRow),
      .oHSync(pHSync), .oVSync(pVSync), .oDisplay(pDisplay),
      .oLineStart(pLineStart), .oFrameStart(pFrameStart));

   vga_timing_gen dutD (
      .Clock(Clock), .Reset(Reset), .iPixelEn(iPixelEn), .oCol(dCol), .oRow(dRow),
      .oHSync(dHSync), .oVSync(dVSync), .oDisplay(dDisplay),
      .oLineStart(dLineStart), .oFrameStart(dFrameStart));

   task automatic check(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // Runs from a fresh reset release; enable is high one Clock in every `period`.
   task automatic runS(input int cycles, input int period, input bit chkD);
      int pos = 0;
      int h, v, dh, dv;
      logic [31:0] eCol = 0, eRow = 0;
      logic eDisp = 0, eHs = 1, eVs = 1, eLs = 0, eFs = 0;
      logic dDispE, dHsE, dVsE;
      logic [31:0] dColE, dRowE;
      for (int k = 0; k < cycles; k++) begin
         iPixelEn = ((k % period) == 0);
         @(posedge Clock); #1;
         if (iPixelEn) begin
            h = pos % 15;  v = (pos / 15) % 8;
            eDisp = (h < 8) && (v < 4);
            eCol  = eDisp ? h : 0;
            eRow  = (v < 4) ? v : 0;
            eHs   = !((h >= 10) && (h <= 12));
            eVs   = !((v == 5) || (v == 6));
            eLs   = (h == 0);
            eFs   = (h == 0) && (v == 0);
            dh = pos % 800;  dv = (pos / 800) % 525;
            dDispE = (dh < 640) && (dv < 480);
            dColE  = dDispE ? dh : 0;
            dRowE  = (dv < 480) ? dv : 0;
            dHsE   = !((dh >= 656) && (dh <= 751));
            dVsE   = !((dv == 490) || (dv == 491));
            pos++;
         end else begin
            eLs = 0;  eFs = 0;
         end
         check("s_col", k, sCol, eCol);
         check("s_row", k, sRow, eRow);
         check("s_display", k, sDisplay, eDisp);
         check("s_hsync", k, sHSync, eHs);
         check("s_vsync", k, sVSync, eVs);
         check("s_linestart", k, sLineStart, eLs);
         check("s_framestart", k, sFrameStart, eFs);
         check("p_hsync", k, pHSync, !eHs);
         check("p_vsync", k, pVSync, !eVs);
         check("p_col", k, pCol, eCol);
         if (chkD) begin
            check("d_col", k, dCol, dColE);
            check("d_row", k, dRow, dRowE);
            check("d_display", k, dDisplay, dDispE);
            check("d_hsync", k, dHSync, dHsE);
            check("d_vsync", k, dVSync, dVsE);
            check("d_linestart", k, dLineStart, (dh == 0));
            check("d_framestart", k, dFrameStart, (dh == 0) && (dv == 0));
         end
      end
   endtask

   initial begin
      Reset = 1'b0;
      iPixelEn = 1'b0;
      #12;
      check("rst_s_col", 0, sCol, 0);
      check("rst_s_row", 0, sRow, 0);
      check("rst_s_display", 0, sDisplay, 0);
      check("rst_s_linestart", 0, sLineStart, 0);
      check("rst_s_framestart", 0, sFrameStart, 0);
      check("rst_s_hsync", 0, sHSync, 1);
      check("rst_s_vsync", 0, sVSync, 1);
      check("rst_p_hsync", 0, pHSync, 0);
      check("rst_p_vsync", 0, pVSync, 0);
      check("rst_d_hsync", 0, dHSync, 1);
      check("rst_d_col", 0, dCol, 0);

      // Continuous enable: two default lines and many small-mode frames
      @(posedge Clock); #1 Reset = 1'b1;
      runS(1600, 1, 1'b1);

      // Async reset in the middle of a visible line (hcnt = 5)
      Reset = 1'b0;
      @(posedge Clock); #1 Reset = 1'b1;
      iPixelEn = 1'b1;
      repeat (5) @(posedge Clock);
      #1;
      check("pre_rst_display", 0, sDisplay, 1);
      check("pre_rst_col", 0, sCol, 4);
      Reset = 1'b0;
      #1;
      check("mid_rst_col", 0, sCol, 0);
      check("mid_rst_display", 0, sDisplay, 0);
      check("mid_rst_hsync", 0, sHSync, 1);
      check("mid_rst_p_hsync", 0, pHSync, 0);
      check("mid_rst_linestart", 0, sLineStart, 0);
      #2 Reset = 1'b1;
      runS(30, 1, 1'b0);

      // One enable in four: one full small frame stretched x4
      Reset = 1'b0;
      @(posedge Clock); #1 Reset = 1'b1;
      runS(488, 4, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
